sp_ram_be: RTL and testbench
============================

# sp_ram_be

Parametrised single-port synchronous RAM with a request/ready handshake, per-byte write enables and a selectable read-during-write mode. It has an optional output pipeline register and a hardware clear sequencer that fills the array with a known value after reset or on command. It replaces the plain single-port RAM wherever a datapath needs deterministic contents, partial-word writes or a read-valid strobe.

## Interface
- ADDR_WIDTH, 4, address width in bits
- DATA_WIDTH, 8, word width; must be a multiple of 8
- DEPTH, 16, number of words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH
- RDW_MODE, 0, write-accept read behaviour: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE
- OUT_REG, 0, 1 adds one output register stage to dout/rvalid/err
- INIT_VALUE, 0, DATA_WIDTH-bit word written to every location by the clear sequencer
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- init  in  1  single-cycle request to re-run the clear sequence
- req  in  1  access request
- we  in  1  1 = write, 0 = read; sampled with req
- be  in  DATA_WIDTH/8  byte write enables; bit i covers din[8i+7:8i]
- addr  in  ADDR_WIDTH  word address
- din  in  DATA_WIDTH  write data
- ready  out  1  block accepts a request this cycle
- rvalid  out  1  one-cycle strobe; dout carries read data
- dout  out  DATA_WIDTH  read data; holds its value between strobes
- err  out  1  one-cycle strobe; the accepted access addressed ≥ DEPTH

## Operation
- An access is accepted when req && ready on a rising edge. No queuing: a req while ready=0 is dropped.
- FSM states are CLEAR and RUN.
  - rst forces CLEAR with cnt=0.
  - In CLEAR, each cycle writes INIT_VALUE to mem[cnt] and increments cnt. The edge that writes cnt=DEPTH-1 moves to RUN.
  - In RUN, ready=1. An init pulse moves to CLEAR with cnt=0 at the next edge. A request accepted in that same cycle is completed first.
  - init asserted during CLEAR restarts cnt at 0.
- Read (we=0):
  - dout ← mem[addr] and rvalid=1.
  - If addr ≥ DEPTH: dout ← 0, rvalid=1, err=1.
- Write (we=1):
  - Bytes with be[i]=1 update; other bytes are retained. be=0 is a legal no-op write.
  - If addr ≥ DEPTH: memory is unchanged and err=1.
  - Data output on a write depends on RDW_MODE:
    - READ_FIRST: dout ← old word, rvalid=1.
    - WRITE_FIRST: dout ← merged new word, rvalid=1.
    - NO_CHANGE: dout holds, rvalid=0.
- The memory array is not reset by rst; only the clear sequencer defines its contents.

## Timing
- Reset values: ready=0, rvalid=0, err=0, dout=0. Pipeline stage registers are also 0.
- ready rises DEPTH clock edges after rst deasserts and stays 1 until init or rst.
- Read latency is 1 cycle with OUT_REG=0 and 2 cycles with OUT_REG=1. rvalid and err are aligned with dout.
- Throughput is one access per cycle. Back-to-back reads to any addresses are valid.
- A read on the cycle after a write to the same address returns the written data.
- ready drops on the edge that samples init. That edge's access is still completed, and its rvalid still appears.
- rst asserted mid-CLEAR or mid-RUN:
  - Outputs go to reset values immediately, including any pipeline stage.
  - Any in-flight read strobe is discarded.
  - The clear sequence restarts from 0.

## Test plan
- Reset release, DEPTH=16, INIT_VALUE=8'hA5: ready rises exactly 16 edges after rst falls; reading addr 0..15 returns 8'hA5 with rvalid 1 cycle later (2 cycles with OUT_REG=1).
- DATA_WIDTH=32: write addr 3 = 32'h11223344 with be=4'b1111, then write 32'hAABBCCDD with be=4'b0101 → read addr 3 returns 32'h11BB33DD.
- RDW_MODE sweep, mem[5]=8'h12, write 8'h34 to addr 5:
  - READ_FIRST: dout=8'h12, rvalid=1.
  - WRITE_FIRST: dout=8'h34, rvalid=1.
  - NO_CHANGE: dout unchanged, rvalid=0.
  - All modes: a subsequent read returns 8'h34.
- ADDR_WIDTH=4, DEPTH=12:
  - Read addr 13 → dout=0, rvalid=1, err=1.
  - Write addr 14 → err=1, and a full readback of addr 0..11 is unchanged.
- init pulse with a same-cycle write of 8'h77 to addr 2: write completes, ready=0 for 16 cycles, then addr 2 reads INIT_VALUE.
- rst pulsed at CLEAR cnt=7: outputs zero asynchronously; after release, ready rises 16 edges later.

Source files
------------

// File: rtl/sp_ram_be.sv
// sp_ram_be: single-port synchronous RAM with request/ready handshake,
// per-byte write enables, selectable read-during-write behaviour, optional
// output register and a clear sequencer that fills the array with INIT_VALUE.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   init   - single-cycle request to re-run the clear sequence
//   req    - access request, accepted when req && ready
//   we     - 1 = write, 0 = read
//   be     - byte write enables, bit i covers din[8i+7:8i]
//   addr   - word address
//   din    - write data
//   ready  - block accepts a request this cycle
//   rvalid - one-cycle strobe, dout carries read data
//   dout   - read data, holds between strobes
//   err    - one-cycle strobe, accepted access addressed >= DEPTH
module sp_ram_be #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init,
    input  logic                    req,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic                    ready,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    err
);

    localparam int unsigned NUM_BYTES   = DATA_WIDTH / 8;
    localparam int unsigned READ_FIRST  = 0;
    localparam int unsigned WRITE_FIRST = 1;
    // One extra bit so DEPTH == 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] new_word;

    logic [DATA_WIDTH-1:0] s_dout;
    logic                  s_rvalid;
    logic                  s_err;

    assign accept   = req && ready;
    assign in_range = {1'b0, addr} < DEPTH_X;
    // Out-of-range addresses never touch the array; steer them to word 0.
    assign idx      = in_range ? addr : '0;
    assign old_word = mem[idx];

    // Byte-lane merge of write data into the current word.
    always_comb begin
        new_word = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) begin
                new_word[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    // Clear/run sequencer; ready is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    if (init) begin
                        cnt <= '0;
                    end else if (cnt == LAST_IDX) begin
                        state <= RUN;
                        ready <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (init) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage array; intentionally not reset, the sequencer defines contents.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= INIT_VALUE;
        end else if (accept && we && in_range) begin
            mem[idx] <= new_word;
        end
    end

    // First output stage: strobes and data for the accepted access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_dout   <= '0;
            s_rvalid <= 1'b0;
            s_err    <= 1'b0;
        end else begin
            s_rvalid <= 1'b0;
            s_err    <= 1'b0;
            if (accept) begin
                s_err <= !in_range;
                if (!we || RDW_MODE == READ_FIRST) begin
                    s_rvalid <= 1'b1;
                    s_dout   <= in_range ? old_word : '0;
                end else if (RDW_MODE == WRITE_FIRST) begin
                    s_rvalid <= 1'b1;
                    s_dout   <= in_range ? new_word : '0;
                end
            end
        end
    end

    // Optional extra output register stage.
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] p_dout;
        logic                  p_rvalid;
        logic                  p_err;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p_dout   <= '0;
                p_rvalid <= 1'b0;
                p_err    <= 1'b0;
            end else begin
                p_dout   <= s_dout;
                p_rvalid <= s_rvalid;
                p_err    <= s_err;
            end
        end

        assign dout   = p_dout;
        assign rvalid = p_rvalid;
        assign err    = p_err;
    end else begin : g_no_out_reg
        assign dout   = s_dout;
        assign rvalid = s_rvalid;
        assign err    = s_err;
    end

endmodule

// File: tb/tb_sp_ram_be.sv
// Testbench for sp_ram_be: three instances (READ_FIRST, WRITE_FIRST with
// output register, NO_CHANGE) share one stimulus stream and are compared
// every cycle against a behavioural memory model.
module tb_sp_ram_be;

    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 12;
    localparam logic [31:0] INIT = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        init;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] din;

    logic        rdy0, rdy1, rdy2;
    logic        rv0, rv1, rv2;
    logic        er0, er1, er2;
    logic [31:0] do0, do1, do2;

    int n_checks = 0;
    int n_pass   = 0;

    sp_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RDW_MODE(0),
                .OUT_REG(0), .INIT_VALUE(INIT)) u0 (
        .clk(clk), .rst(rst), .init(init), .req(req), .we(we), .be(be),
        .addr(addr), .din(din), .ready(rdy0), .rvalid(rv0), .dout(do0), .err(er0));

    sp_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RDW_MODE(1),
                .OUT_REG(1), .INIT_VALUE(INIT)) u1 (
        .clk(clk), .rst(rst), .init(init), .req(req), .we(we), .be(be),
        .addr(addr), .din(din), .ready(rdy1), .rvalid(rv1), .dout(do1), .err(er1));

    sp_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .RDW_MODE(2),
                .OUT_REG(0), .INIT_VALUE(INIT)) u2 (
        .clk(clk), .rst(rst), .init(init), .req(req), .we(we), .be(be),
        .addr(addr), .din(din), .ready(rdy2), .rvalid(rv2), .dout(do2), .err(er2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] m_mem [DEP];
    bit          m_ready;
    int          m_left;
    logic [31:0] e_dout [3];
    bit          e_rv   [3];
    bit          e_err  [3];
    logic [31:0] p_dout;
    bit          p_rv;
    bit          p_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            e_dout[m] = '0;
            e_rv[m]   = 1'b0;
            e_err[m]  = 1'b0;
        end
        p_dout  = '0;
        p_rv    = 1'b0;
        p_err   = 1'b0;
        m_ready = 1'b0;
        m_left  = DEP;
    endtask

    // Apply the rules for one rising edge using the inputs present at it.
    task automatic model_edge();
        logic [31:0] oldw;
        logic [31:0] neww;
        bit          inr;
        int          a;
        if (rst) begin
            model_reset();
            return;
        end
        p_dout = e_dout[1];
        p_rv   = e_rv[1];
        p_err  = e_err[1];
        for (int m = 0; m < 3; m++) begin
            e_rv[m]  = 1'b0;
            e_err[m] = 1'b0;
        end
        if (m_ready && req) begin
            a    = int'(addr);
            inr  = a < DEP;
            oldw = inr ? m_mem[a] : 32'h0;
            neww = oldw;
            for (int b = 0; b < 4; b++)
                if (be[b]) neww[8*b +: 8] = din[8*b +: 8];
            for (int m = 0; m < 3; m++) begin
                e_err[m] = !inr;
                if (!we || m == 0) begin
                    e_rv[m]   = 1'b1;
                    e_dout[m] = oldw;
                end else if (m == 1) begin
                    e_rv[m]   = 1'b1;
                    e_dout[m] = inr ? neww : 32'h0;
                end
            end
            if (we && inr) m_mem[a] = neww;
        end
        if (m_ready) begin
            if (init) begin
                m_ready = 1'b0;
                m_left  = DEP;
            end
        end else if (init) begin
            m_left = DEP;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEP; i++) m_mem[i] = INIT;
            end
        end
    endtask

    task automatic compare_all();
        check("ready0", 32'(rdy0), 32'(m_ready));
        check("ready1", 32'(rdy1), 32'(m_ready));
        check("ready2", 32'(rdy2), 32'(m_ready));
        check("rvalid0", 32'(rv0), 32'(e_rv[0]));
        check("err0", 32'(er0), 32'(e_err[0]));
        check("dout0", do0, e_dout[0]);
        check("rvalid1", 32'(rv1), 32'(p_rv));
        check("err1", 32'(er1), 32'(p_err));
        check("dout1", do1, p_dout);
        check("rvalid2", 32'(rv2), 32'(e_rv[2]));
        check("err2", 32'(er2), 32'(e_err[2]));
        check("dout2", do2, e_dout[2]);
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        req  = 1'b0;
        we   = 1'b0;
        init = 1'b0;
    endtask

    task automatic access(input bit w, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        req  = 1'b1;
        we   = w;
        addr = a;
        din  = d;
        be   = b;
        step();
        idle();
    endtask

    // Count edges until ready rises, bounded.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (n < 40) begin
            step();
            n++;
            if (rdy0) break;
        end
        check(tag, 32'(n), 32'(DEP));
    endtask

    task automatic async_reset_check(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check({tag, "_ready"}, 32'(rdy0 | rdy1 | rdy2), 32'h0);
        check({tag, "_rvalid"}, 32'(rv0 | rv1 | rv2), 32'h0);
        check({tag, "_err"}, 32'(er0 | er1 | er2), 32'h0);
        check({tag, "_dout"}, do0 | do1 | do2, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        init = 1'b0;
        req  = 1'b0;
        we   = 1'b0;
        be   = '0;
        addr = '0;
        din  = '0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        wait_ready("ready_after_reset");

        // Every location holds INIT_VALUE after the clear.
        for (int i = 0; i < DEP; i++) begin
            access(1'b0, 4'(i), 32'h0, 4'h0);
            check("init_read", do0, INIT);
        end
        step();

        // Partial-word write merge.
        access(1'b1, 4'd3, 32'h1122_3344, 4'b1111);
        access(1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101);
        access(1'b0, 4'd3, 32'h0, 4'h0);
        check("be_merge", do0, 32'h11BB_33DD);
        step();

        // Read-during-write behaviour per mode.
        access(1'b1, 4'd5, 32'h12, 4'b1111);
        access(1'b1, 4'd5, 32'h34, 4'b1111);
        check("rf_dout", do0, 32'h12);
        check("nc_rvalid", 32'(rv2), 32'h0);
        step();
        check("wf_dout", do1, 32'h34);
        access(1'b0, 4'd5, 32'h0, 4'h0);
        check("rdw_readback", do2, 32'h34);
        step();

        // Out-of-range accesses.
        access(1'b0, 4'd13, 32'h0, 4'h0);
        check("oor_err", 32'(er0), 32'h1);
        check("oor_dout", do0, 32'h0);
        access(1'b1, 4'd14, 32'hDEAD_BEEF, 4'b1111);
        check("oor_werr", 32'(er2), 32'h1);
        access(1'b1, 4'd4, 32'h0, 4'b0000);
        for (int i = 0; i < DEP; i++) access(1'b0, 4'(i), 32'h0, 4'h0);
        step();

        // init with a same-cycle write.
        init = 1'b1;
        access(1'b1, 4'd2, 32'h77, 4'b1111);
        check("init_ready_low", 32'(rdy0), 32'h0);
        check("init_write_done", do0, INIT);
        wait_ready("ready_after_init");
        access(1'b0, 4'd2, 32'h0, 4'h0);
        check("init_cleared", do0, INIT);
        step();

        // rst at CLEAR cnt=7.
        init = 1'b1;
        step();
        init = 1'b0;
        repeat (7) step();
        async_reset_check("rst_clear");
        step();
        rst = 1'b0;
        wait_ready("ready_after_rst_clear");

        // rst in RUN with a read still in the output register.
        access(1'b0, 4'd1, 32'h0, 4'h0);
        async_reset_check("rst_run");
        step();
        rst = 1'b0;
        wait_ready("ready_after_rst_run");

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                idle();
                rst = 1'b1;
                model_reset();
                step();
                rst = 1'b0;
            end else begin
                req  = ($urandom_range(0, 3) != 0);
                we   = 1'($urandom_range(0, 1));
                addr = 4'($urandom_range(0, 15));
                din  = $urandom;
                be   = 4'($urandom_range(0, 15));
                init = ($urandom_range(0, 79) == 0);
                step();
            end
        end
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
